tmds_decoder: RTL



---
 rtl/tmds_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder
// Brief    : One TMDS receive channel: finds the character boundary in an
//            arbitrarily aligned 10-bit word stream, then decodes data/control.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_decoder #(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_WIN = 4096,
    parameter int LOSS_WIN   = 4096
) (
    input  logic       pixel_clk,
    input  logic       sys_rst,
    input  logic [9:0] din,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic [7:0] data,
    output logic       ctrl_token,
    output logic       locked,
    output logic [3:0] offset
);

    localparam logic [15:0] c_run_lock  = 16'(CTRL_RUN);
    localparam logic [15:0] c_win_last  = 16'(SEARCH_WIN - 1);
    localparam logic [15:0] c_loss_last = 16'(LOSS_WIN - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t      r_state;
    logic [9:0]  r_d1;
    logic [9:0]  r_d2;
    logic [3:0]  r_offset;
    logic [15:0] r_run;
    logic [15:0] r_win;
    logic [15:0] r_loss;
    logic        r_locked;
    logic        r_de;
    logic        r_tok;
    logic [1:0]  r_c;
    logic [7:0]  r_data;

    logic [19:0] w_cat;
    logic [9:0]  w_char;
    logic        w_is_tok;
    logic [1:0]  w_tok_c;
    logic [7:0]  w_t;
    logic [6:0]  w_x;
    logic [7:0]  w_dec;
    logic [3:0]  w_off_next;

    // d2 holds the earlier word, so it sits in the low (earlier) bit positions
    assign w_cat      = {r_d1, r_d2};
    assign w_char     = 10'(w_cat >> r_offset);
    assign w_off_next = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

    always_comb begin
        w_is_tok = 1'b1;
        w_tok_c  = 2'b00;
        case (w_char)
            10'h354: w_tok_c = 2'b00;
            10'h0AB: w_tok_c = 2'b01;
            10'h154: w_tok_c = 2'b10;
            10'h2AB: w_tok_c = 2'b11;
            default: w_is_tok = 1'b0;
        endcase
    end

    // bit 9 flags inversion, bit 8 selects XOR (1) or XNOR (0) chaining
    assign w_t   = w_char[9] ? ~w_char[7:0] : w_char[7:0];
    assign w_x   = w_t[7:1] ^ w_t[6:0];
    assign w_dec = {(w_char[8] ? w_x : ~w_x), w_t[0]};

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            r_state  <= ST_SEARCH;
            r_d1     <= 10'd0;
            r_d2     <= 10'd0;
            r_offset <= 4'd0;
            r_run    <= 16'd0;
            r_win    <= 16'd0;
            r_loss   <= 16'd0;
            r_locked <= 1'b0;
            r_de     <= 1'b0;
            r_tok    <= 1'b0;
            r_c      <= 2'b00;
            r_data   <= 8'd0;
        end else begin
            r_d1  <= din;
            r_d2  <= r_d1;
            r_tok <= w_is_tok;

            if (!r_locked) begin
                r_de   <= 1'b0;
                r_c    <= 2'b00;
                r_data <= 8'd0;
            end else if (w_is_tok) begin
                r_de   <= 1'b0;
                r_c    <= w_tok_c;
                r_data <= 8'd0;
            end else begin
                r_de   <= 1'b1;
                r_data <= w_dec;
            end

            if (r_state == ST_SEARCH) begin
                // lock takes priority over a window expiry on the same cycle
                if (r_run == c_run_lock) begin
                    r_state  <= ST_LOCKED;
                    r_locked <= 1'b1;
                    r_run    <= 16'd0;
                    r_win    <= 16'd0;
                    r_loss   <= 16'd0;
                end else if (r_win == c_win_last) begin
                    r_offset <= w_off_next;
                    r_run    <= 16'd0;
                    r_win    <= 16'd0;
                end else begin
                    r_run <= w_is_tok ? r_run + 16'd1 : 16'd0;
                    r_win <= r_win + 16'd1;
                end
            end else begin
                if (r_loss == c_loss_last) begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                    r_offset <= w_off_next;
                    r_run    <= 16'd0;
                    r_win    <= 16'd0;
                    r_loss   <= 16'd0;
                end else begin
                    r_loss <= w_is_tok ? 16'd0 : r_loss + 16'd1;
                end
            end
        end
    end

    assign de         = r_de;
    assign c1         = r_c[1];
    assign c0         = r_c[0];
    assign data       = r_data;
    assign ctrl_token = r_tok;
    assign locked     = r_locked;
    assign offset     = r_offset;

endmodule
`default_nettype wire
